// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_divider_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ITERATE,
        FIXUP,
        DONE
    } state_t;

    // Number of bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One restoring-division step: shift a dividend bit into the accumulator and trial-subtract.
module seq_divider_step
    import seq_divider_pkg::*;
#(
    parameter int DIVISOR_WIDTH = 8
) (
    input  logic [DIVISOR_WIDTH:0]   i_acc,
    input  logic                     i_bit,
    input  logic [DIVISOR_WIDTH-1:0] i_dmag,
    output logic [DIVISOR_WIDTH:0]   o_acc,
    output logic                     o_q_bit
);

    // One guard bit above the shifted accumulator keeps the trial subtraction free of wrap-around.
    logic [DIVISOR_WIDTH+1:0] w_shifted;
    logic [DIVISOR_WIDTH+1:0] w_diff;
    logic [DIVISOR_WIDTH+1:0] w_pick;

    assign w_shifted = {i_acc, i_bit};
    assign w_diff    = w_shifted - {2'b00, i_dmag};
    assign o_q_bit   = (w_shifted >= {2'b00, i_dmag});
    assign w_pick    = o_q_bit ? w_diff : w_shifted;
    assign o_acc     = (DIVISOR_WIDTH + 1)'(w_pick);

endmodule

// File: rtl/seq_divider.sv
// Iterative signed/unsigned divider with valid/ready handshakes, one quotient bit per cycle.
// Optional SEQ_DIVIDER_EARLY_EXIT_EN: finish in SETUP when |dividend| < |divisor|.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = 16,
    parameter int DIVISOR_WIDTH  = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_signed,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      div_by_zero,
    output logic                      overflow
);

    localparam int DW    = DIVIDEND_WIDTH;
    localparam int VW    = DIVISOR_WIDTH;
    localparam int CNT_W = clog2(DW + 1);
    localparam int CMP_W = (DW > VW) ? DW : VW;

    state_t          r_state;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_signed;
    logic [DW-1:0]   r_dividend;
    logic [VW-1:0]   r_divisor;
    logic [VW:0]     r_acc;
    logic [DW-1:0]   r_shift;
    logic [VW-1:0]   r_dmag;
    logic [CNT_W-1:0] r_cnt;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [DW-1:0]   r_quotient;
    logic [VW-1:0]   r_remainder;
    logic            r_div_by_zero;
    logic            r_overflow;

    logic            w_dvd_neg;
    logic            w_dsr_neg;
    logic [DW-1:0]   w_dvd_mag;
    logic [VW-1:0]   w_dsr_mag;
    logic            w_dsr_zero;
    logic            w_ovf;
    logic [VW-1:0]   w_zext_rem;
    logic [VW:0]     w_acc_next;
    logic            w_q_bit;

    // Sign bits only count as signs in signed mode.
    assign w_dvd_neg  = r_signed & r_dividend[DW-1];
    assign w_dsr_neg  = r_signed & r_divisor[VW-1];
    assign w_dvd_mag  = w_dvd_neg ? -r_dividend : r_dividend;
    assign w_dsr_mag  = w_dsr_neg ? -r_divisor : r_divisor;
    assign w_dsr_zero = (r_divisor == '0);
    assign w_ovf      = r_signed && (r_dividend == {1'b1, {(DW-1){1'b0}}}) && (r_divisor == '1);

    generate
        if (DW >= VW) begin : g_zext_trunc
            assign w_zext_rem = r_dividend[VW-1:0];
        end else begin : g_zext_pad
            assign w_zext_rem = {{(VW-DW){1'b0}}, r_dividend};
        end
    endgenerate

`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
    logic            w_early;
    logic [VW-1:0]   w_sext_rem;
    logic [VW-1:0]   w_early_rem;

    generate
        if (DW >= VW) begin : g_sext_trunc
            assign w_sext_rem = r_dividend[VW-1:0];
        end else begin : g_sext_pad
            assign w_sext_rem = {{(VW-DW){r_dividend[DW-1]}}, r_dividend};
        end
    endgenerate

    assign w_early     = (CMP_W'(w_dvd_mag) < CMP_W'(w_dsr_mag));
    assign w_early_rem = r_signed ? w_sext_rem : w_zext_rem;
`endif

    seq_divider_step #(
        .DIVISOR_WIDTH(VW)
    ) u_step (
        .i_acc  (r_acc),
        .i_bit  (r_shift[DW-1]),
        .i_dmag (r_dmag),
        .o_acc  (w_acc_next),
        .o_q_bit(w_q_bit)
    );

    // Special cases preload r_shift/r_acc with the final result and pass through FIXUP with
    // negation disabled, so every result is published by the same FIXUP->DONE transfer.
    // NOTE: datapath registers are reset too, so outputs read 0 after reset rather than X.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_signed      <= 1'b0;
            r_dividend    <= '0;
            r_divisor     <= '0;
            r_acc         <= '0;
            r_shift       <= '0;
            r_dmag        <= '0;
            r_cnt         <= '0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            // NOTE: every register here uses <=, so all reads in this block see pre-edge values.
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_signed      <= in_signed;
                        r_dividend    <= dividend;
                        r_divisor     <= divisor;
                        r_div_by_zero <= 1'b0;
                        r_overflow    <= 1'b0;
                        r_in_ready    <= 1'b0;
                        r_state       <= SETUP;
                    end
                end

                SETUP: begin
                    r_neg_q <= w_dvd_neg ^ w_dsr_neg;
                    r_neg_r <= w_dvd_neg;
                    r_acc   <= '0;
                    r_shift <= w_dvd_mag;
                    r_dmag  <= w_dsr_mag;
                    r_cnt   <= CNT_W'(DW);
                    r_state <= ITERATE;
                    if (w_dsr_zero) begin
                        r_neg_q       <= 1'b0;
                        r_neg_r       <= 1'b0;
                        r_shift       <= '1;
                        r_acc         <= {1'b0, w_zext_rem};
                        r_div_by_zero <= 1'b1;
                        r_state       <= FIXUP;
                    end else if (w_ovf) begin
                        r_neg_q    <= 1'b0;
                        r_neg_r    <= 1'b0;
                        r_shift    <= {1'b1, {(DW-1){1'b0}}};
                        r_acc      <= '0;
                        r_overflow <= 1'b1;
                        r_state    <= FIXUP;
                    end
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
                    else if (w_early) begin
                        r_neg_q <= 1'b0;
                        r_neg_r <= 1'b0;
                        r_shift <= '0;
                        r_acc   <= {1'b0, w_early_rem};
                        r_state <= FIXUP;
                    end
`endif
                end

                ITERATE: begin
                    r_acc   <= w_acc_next;
                    r_shift <= {r_shift[DW-2:0], w_q_bit};
                    r_cnt   <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= FIXUP;
                    end
                end

                FIXUP: begin
                    r_quotient  <= r_neg_q ? -r_shift : r_shift;
                    r_remainder <= r_neg_r ? -r_acc[VW-1:0] : r_acc[VW-1:0];
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end

                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (8-bit dividend, 4-bit divisor); honours SEQ_DIVIDER_EARLY_EXIT_EN.
module tb_seq_divider;

    localparam int DW = 8;
    localparam int VW = 4;
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
    localparam int EARLY_LAT = 2;
`else
    localparam int EARLY_LAT = DW + 2;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          in_signed;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;
    logic          overflow;

    seq_divider #(
        .DIVIDEND_WIDTH(DW),
        .DIVISOR_WIDTH (VW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_signed  (in_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int edges = 0;

    always @(posedge clock) edges <= edges + 1;

    typedef struct {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dbz;
        logic          ovf;
        int            lat;
        int            acc;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result from plain integer arithmetic (SV / and % truncate toward zero).
    function automatic exp_t model(input logic sgn, input logic [DW-1:0] a, input logic [VW-1:0] b);
        exp_t e;
        int   sa;
        int   sb;
        int   q;
        int   r;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        e.lat = DW + 2;
        e.acc = 0;
        sa = sgn ? int'($signed(a)) : int'(a);
        sb = sgn ? int'($signed(b)) : int'(b);
        if (sb == 0) begin
            e.q   = '1;
            e.r   = a[VW-1:0];
            e.dbz = 1'b1;
            e.lat = 2;
        end else if (sgn && sa == -(1 << (DW - 1)) && sb == -1) begin
            e.q   = {1'b1, {(DW-1){1'b0}}};
            e.r   = '0;
            e.ovf = 1'b1;
            e.lat = 2;
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            e.q = q[DW-1:0];
            e.r = r[VW-1:0];
            if (((sa < 0) ? -sa : sa) < ((sb < 0) ? -sb : sb)) begin
                e.lat = EARLY_LAT;
            end
        end
        return e;
    endfunction

    // Compare process: every cycle out_valid is high, outputs must match the oldest expectation.
    logic prev_valid = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            prev_valid <= 1'b0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    check("cmp_quotient", {24'd0, quotient}, {24'd0, exp_q[0].q});
                    check("cmp_remainder", {28'd0, remainder}, {28'd0, exp_q[0].r});
                    check("cmp_div_by_zero", {31'd0, div_by_zero}, {31'd0, exp_q[0].dbz});
                    check("cmp_overflow", {31'd0, overflow}, {31'd0, exp_q[0].ovf});
                    check("cmp_in_ready_busy", {31'd0, in_ready}, 32'd0);
                    if (!prev_valid) begin
                        check("cmp_latency", edges - exp_q[0].acc, exp_q[0].lat);
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_valid <= out_valid;
        end
    end

    // Present operands and wait (bounded) for the accepting edge; returns at accept edge + 1.
    task automatic start(input logic sgn, input logic [DW-1:0] a, input logic [VW-1:0] b,
                         output int acc_edge);
        logic rdy;
        bit   accepted;
        exp_t e;
        in_signed = sgn;
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        accepted  = 1'b0;
        acc_edge  = 0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clock);
            rdy = in_ready;
            @(posedge clock);
            #1;
            accepted = (rdy === 1'b1);
        end
        check("accept", {31'd0, accepted}, 32'd1);
        if (accepted) begin
            acc_edge = edges;
            e        = model(sgn, a, b);
            e.acc    = edges;
            exp_q.push_back(e);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit found);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            found = (out_valid === 1'b1);
        end
        check("out_valid_timeout", {31'd0, found}, 32'd1);
    endtask

    // Directed transaction with hand-computed literals; out_ready must already be 1.
    task automatic run_div(input logic sgn, input logic [DW-1:0] a, input logic [VW-1:0] b,
                           input logic [DW-1:0] eq, input logic [VW-1:0] er,
                           input logic ed, input logic eo, input int elat);
        int acc_edge;
        bit found;
        start(sgn, a, b, acc_edge);
        wait_valid(found);
        if (found) begin
            check("lit_quotient", {24'd0, quotient}, {24'd0, eq});
            check("lit_remainder", {28'd0, remainder}, {28'd0, er});
            check("lit_div_by_zero", {31'd0, div_by_zero}, {31'd0, ed});
            check("lit_overflow", {31'd0, overflow}, {31'd0, eo});
            check("lit_latency", edges - acc_edge, elat);
            @(posedge clock);
            #1;
            check("release_out_valid", {31'd0, out_valid}, 32'd0);
            check("release_in_ready", {31'd0, in_ready}, 32'd1);
        end
    endtask

    typedef struct {
        logic          sgn;
        logic [DW-1:0] a;
        logic [VW-1:0] b;
    } vec_t;

    vec_t extra[$];
    exp_t m;
    int   acc_edge;
    bit   found;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b1;

        // Pin the model against hand-computed values.
        m = model(1'b1, 8'hEF, 4'h2);
        check("model_q_m17_2", {24'd0, m.q}, 32'hF8);
        check("model_r_m17_2", {28'd0, m.r}, 32'hF);
        m = model(1'b0, 8'd37, 4'd0);
        check("model_q_div0", {24'd0, m.q}, 32'hFF);
        check("model_r_div0", {28'd0, m.r}, 32'h5);
        check("model_dbz_div0", {31'd0, m.dbz}, 32'd1);
        m = model(1'b1, 8'h80, 4'hF);
        check("model_q_ovf", {24'd0, m.q}, 32'h80);
        check("model_ovf", {31'd0, m.ovf}, 32'd1);

        repeat (2) @(posedge clock);
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_quotient", {24'd0, quotient}, 32'd0);
        check("reset_remainder", {28'd0, remainder}, 32'd0);
        check("reset_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;

        run_div(1'b1, 8'hEF, 4'h2, 8'hF8, 4'hF, 1'b0, 1'b0, 10);
        run_div(1'b0, 8'hEF, 4'h2, 8'd119, 4'd1, 1'b0, 1'b0, 10);
        run_div(1'b0, 8'd99, 4'd3, 8'd33, 4'd0, 1'b0, 1'b0, 10);
        run_div(1'b0, 8'd37, 4'd0, 8'hFF, 4'h5, 1'b1, 1'b0, 2);
        run_div(1'b1, 8'h80, 4'hF, 8'h80, 4'h0, 1'b0, 1'b1, 2);

        // Backpressure: result held for several cycles while in_valid is offered and ignored.
        out_ready = 1'b0;
        start(1'b0, 8'd15, 4'd15, acc_edge);
        wait_valid(found);
        check("stall_quotient", {24'd0, quotient}, 32'd1);
        check("stall_remainder", {28'd0, remainder}, 32'd0);
        check("stall_latency", edges - acc_edge, 10);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            in_valid  = 1'b1;
            in_signed = 1'b0;
            dividend  = 8'h11;
            divisor   = 4'h1;
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        check("stall_release_valid", {31'd0, out_valid}, 32'd0);
        check("stall_release_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clock);
        #1;
        check("stall_no_accept", {31'd0, in_ready}, 32'd1);
        check("stall_no_valid", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset in the middle of ITERATE, between clock edges.
        start(1'b0, 8'd85, 4'd4, acc_edge);
        repeat (4) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        check("midreset_quotient", {24'd0, quotient}, 32'd0);
        @(posedge clock);
        #3;
        reset = 1'b0;
        @(posedge clock);
        #1;
        run_div(1'b0, 8'd85, 4'd4, 8'd21, 4'd1, 1'b0, 1'b0, 10);

        // |dividend| < |divisor|: same result either way, latency depends on the build.
        run_div(1'b1, 8'hFE, 4'h5, 8'h00, 4'hE, 1'b0, 1'b0, EARLY_LAT);

        // Further vectors checked only by the compare process against the model.
        extra.push_back('{1'b1, 8'h7F, 4'h8});
        extra.push_back('{1'b1, 8'h80, 4'h3});
        extra.push_back('{1'b0, 8'hFF, 4'hF});
        extra.push_back('{1'b1, 8'h05, 4'hD});
        extra.push_back('{1'b0, 8'h00, 4'h7});
        extra.push_back('{1'b1, 8'h9C, 4'h0});
        extra.push_back('{1'b1, 8'h03, 4'hF});
        foreach (extra[i]) begin
            start(extra[i].sgn, extra[i].a, extra[i].b, acc_edge);
            wait_valid(found);
            @(posedge clock);
            #1;
        end

        repeat (3) @(posedge clock);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
